// File: rtl/shared_adder_pkg.sv
// rtl/shared_adder_pkg.sv - shared types and default sizing for the shared adder arbiter
package shared_adder_pkg;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/shared_adder_arb_add_core.sv
// rtl/shared_adder_arb_add_core.sv - combinational adder with carry-out
// SHARED_ADDER_SAT_EN clamps the sum to all-ones on carry-out; carry is still reported.
module add_core
  import shared_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH:0] full;

  always_comb begin
    full  = {1'b0, a} + {1'b0, b};
    carry = full[WIDTH];
`ifdef SHARED_ADDER_SAT_EN
    sum = full[WIDTH] ? {WIDTH{1'b1}} : full[WIDTH-1:0];
`else
    sum = full[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/shared_adder_arb.sv
// rtl/shared_adder_arb.sv - round-robin arbiter sharing one adder among NUM_REQ requesters
// Saturating arithmetic is selected inside add_core by SHARED_ADDER_SAT_EN.
module shared_adder_arb
  import shared_adder_pkg::*;
#(
  parameter  int NUM_REQ = DEFAULT_NUM_REQ,
  parameter  int WIDTH   = DEFAULT_WIDTH,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic [ID_W-1:0]          rsp_id
);

  state_t           state, state_nxt;
  logic [ID_W-1:0]  ptr, ptr_nxt, grant_id, idx_l, id_q;
  logic             found, accept;
  int               idx;
  logic [WIDTH-1:0] a_q, b_q, sum_q, add_sum;
  logic             carry_q, add_carry;

  // Scan from the pointer upward; iterating downward lets the nearest valid index win.
  always_comb begin
    found    = 1'b0;
    grant_id = '0;
    idx      = 0;
    idx_l    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx   = (int'(ptr) + k) % NUM_REQ;
      idx_l = ID_W'(idx);
      if (req_valid[idx_l]) begin
        found    = 1'b1;
        grant_id = idx_l;
      end
    end
  end

  always_comb begin
    ptr_nxt = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    accept  = (state == IDLE) && found && !rst;
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  add_core #(.WIDTH(WIDTH)) u_add (
    .a     (a_q),
    .b     (b_q),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q  <= req_a[grant_id*WIDTH +: WIDTH];
        b_q  <= req_b[grant_id*WIDTH +: WIDTH];
        id_q <= grant_id;
        ptr  <= ptr_nxt;
      end
      if (state == CALC) begin
        sum_q   <= add_sum;
        carry_q <= add_carry;
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_shared_adder_arb.sv
// tb/tb_shared_adder_arb.sv - directed self-checking bench for shared_adder_arb
module tb_shared_adder_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_sum;
  logic        rsp_carry;
  logic [1:0]  rsp_id;

  int checks = 0;
  int errors = 0;

`ifdef SHARED_ADDER_SAT_EN
  localparam logic [7:0] OVF_SUM = 8'd255;
`else
  localparam logic [7:0] OVF_SUM = 8'd44;
`endif

  always #5 clk = ~clk;

  shared_adder_arb #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id)
  );

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b1;
    req_a = 32'h11223344; req_b = 32'hF0E0D0C0;
    step; step;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_sum !== 8'd0) begin errors++; $display("FAIL reset_sum: got %0d expected 0", rsp_sum); end
    checks++; if (rsp_carry !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", rsp_carry); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", rsp_id); end
    rst = 1'b0; req_valid = 4'h0; rsp_ready = 1'b0;
    #1;
  endtask

  task automatic test_single;
    req_valid = 4'b0001; set_op(0, 8'd10, 8'd15);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
    step;
    req_valid = 4'b0000; #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_calc_ready: got %b expected 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_calc_valid: got %b expected 0", rsp_valid); end
    step;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
    checks++; if (rsp_sum !== 8'd25) begin errors++; $display("FAIL single_sum: got %0d expected 25", rsp_sum); end
    checks++; if (rsp_carry !== 1'b0) begin errors++; $display("FAIL single_carry: got %b expected 0", rsp_carry); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_id: got %0d expected 0", rsp_id); end
    rsp_ready = 1'b1;
    step;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_release: got %b expected 0", rsp_valid); end
    rsp_ready = 1'b0;
  endtask

  task automatic test_overflow;
    set_op(1, 8'd255, 8'd255); set_op(3, 8'd1, 8'd2);
    set_op(2, 8'd200, 8'd100);
    req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL ovf_grant: got %b expected 0100", req_ready); end
    step;
    req_valid = 4'b0000;
    step;
    checks++; if (rsp_sum !== OVF_SUM) begin errors++; $display("FAIL ovf_sum: got %0d expected %0d", rsp_sum, OVF_SUM); end
    checks++; if (rsp_carry !== 1'b1) begin errors++; $display("FAIL ovf_carry: got %b expected 1", rsp_carry); end
    checks++; if (rsp_id !== 2'd2) begin errors++; $display("FAIL ovf_id: got %0d expected 2", rsp_id); end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
  endtask

  task automatic test_fairness;
    logic [3:0] exp_ready;
    logic [7:0] exp_sum;
    int g;
    rst = 1'b1;
    step;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 8'(i*20 + 5), 8'(i + 1));
    req_valid = 4'hF; rsp_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      g = (cyc / 3) % 4;
      exp_ready = (cyc % 3 == 0) ? (4'b0001 << g) : 4'b0000;
      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL fair_ready cyc%0d: got %b expected %b", cyc, req_ready, exp_ready); end
      checks++; if (rsp_valid !== (cyc % 3 == 2)) begin errors++; $display("FAIL fair_valid cyc%0d: got %b expected %b", cyc, rsp_valid, cyc % 3 == 2); end
      if (cyc % 3 == 2) begin
        exp_sum = 8'(21*g + 6);
        checks++; if (rsp_id !== 2'(g)) begin errors++; $display("FAIL fair_id cyc%0d: got %0d expected %0d", cyc, rsp_id, g); end
        checks++; if (rsp_sum !== exp_sum) begin errors++; $display("FAIL fair_sum cyc%0d: got %0d expected %0d", cyc, rsp_sum, exp_sum); end
      end
      if (cyc < 14) step;
    end
    req_valid = 4'h0;
    step;
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    set_op(3, 8'd7, 8'd8);
    req_valid = 4'b1000; #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_grant: got %b expected 1000", req_ready); end
    step;
    req_valid = 4'hF; #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_calc_ready: got %b expected 0000", req_ready); end
    step;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid hold%0d: got %b expected 1", i, rsp_valid); end
      checks++; if (rsp_sum !== 8'd15 || rsp_carry !== 1'b0 || rsp_id !== 2'd3) begin errors++; $display("FAIL bp_data hold%0d: got sum %0d carry %b id %0d expected 15 0 3", i, rsp_sum, rsp_carry, rsp_id); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready hold%0d: got %b expected 0000", i, req_ready); end
      step;
    end
    rsp_ready = 1'b1;
    step;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b expected 0", rsp_valid); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_grant: got %b expected 0001", req_ready); end
    req_valid = 4'h0; rsp_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid;
    set_op(1, 8'd50, 8'd60);
    req_valid = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rm_grant: got %b expected 0010", req_ready); end
    step;
    req_valid = 4'h0; rst = 1'b1; #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_in_reset: got %b expected 0", rsp_valid); end
    step;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_no_rsp cyc%0d: got %b expected 0", i, rsp_valid); end
      step;
    end
    req_valid = 4'b0110; #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rm_ptr_reset: got %b expected 0010", req_ready); end
    step;
    req_valid = 4'h0; rsp_ready = 1'b1;
    step;
    checks++; if (rsp_sum !== 8'd110 || rsp_id !== 2'd1) begin errors++; $display("FAIL rm_rsp: got sum %0d id %0d expected 110 1", rsp_sum, rsp_id); end
    step;
  endtask

  task automatic test_withdraw;
    set_op(0, 8'd3, 8'd4);
    req_valid = 4'b0001; #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wd_grant0: got %b expected 0001", req_ready); end
    step;
    req_valid = 4'b0010; #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL wd_busy_ready: got %b expected 0000", req_ready); end
    step;
    checks++; if (rsp_valid !== 1'b1 || rsp_sum !== 8'd7 || rsp_id !== 2'd0) begin errors++; $display("FAIL wd_rsp: got valid %b sum %0d id %0d expected 1 7 0", rsp_valid, rsp_sum, rsp_id); end
    req_valid = 4'b0000;
    step;
    for (int i = 0; i < 4; i++) begin
      checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin errors++; $display("FAIL wd_idle cyc%0d: got ready %b valid %b expected 0000 0", i, req_ready, rsp_valid); end
      step;
    end
    req_valid = 4'b0100; #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL wd_other_grant: got %b expected 0100", req_ready); end
    req_valid = 4'h0; rsp_ready = 1'b0;
    #1;
  endtask

  initial begin
    test_reset;
    test_single;
    test_overflow;
    test_fairness;
    test_backpressure;
    test_reset_mid;
    test_withdraw;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_adder_arb.md
SHARED_ADDER_ARB -- requirements
Module: shared_adder_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-002 Parameter WIDTH, default 8: operand and sum width.
REQ-003 Ports:
  - clk, input, 1: single clock, rising edge.
  - rst, input, 1: asynchronous, active-high reset.
REQ-004 Port req_valid, input, NUM_REQ: per-requester operand valid.
REQ-005 Port req_ready, output, NUM_REQ: one-hot grant/accept strobe.
REQ-006 Port req_a, input, NUM_REQ*WIDTH: operand A; requester i occupies slice [i*WIDTH +: WIDTH].
REQ-007 Port req_b, input, NUM_REQ*WIDTH: operand B, same packing as req_a.
REQ-008 Port rsp_valid, output, 1: result valid.
REQ-009 Port rsp_ready, input, 1: result consumed.
REQ-010 Port rsp_sum, output, WIDTH: sum.
REQ-011 Port rsp_carry, output, 1: carry-out of the addition.
REQ-012 Port rsp_id, output, clog2(NUM_REQ): index of the requester that owns the result.

Function
REQ-013 FSM SHALL have states IDLE, CALC and RESP.
REQ-014 In IDLE, when any req_valid bit is high, the block SHALL select one requester round-robin and assert that requester's req_ready bit combinationally in the same cycle.
REQ-015 On that edge the block SHALL capture a, b and the requester id, then move to CALC.
REQ-016 A transfer SHALL occur only when req_valid[i] and req_ready[i] are both high.
REQ-017 req_ready SHALL be all-zero in CALC and RESP, and at most one bit SHALL be high in any cycle.
REQ-018 CALC SHALL register {carry, sum} = a + b computed at WIDTH+1 bits, then go to RESP. Sum wraps modulo 2^WIDTH.
REQ-019 In RESP, rsp_valid SHALL be 1 and rsp_sum, rsp_carry and rsp_id SHALL stay stable until rsp_ready is high. On that edge the FSM SHALL return to IDLE.
REQ-020 Latency: acceptance at edge N SHALL give rsp_valid high from edge N+2. Minimum spacing between acceptances is 3 cycles.
REQ-021 Round-robin: after a grant to requester g, priority SHALL start at (g+1) mod NUM_REQ. The pointer SHALL be unchanged when nothing is granted.
REQ-022 A requester that drops req_valid before it is granted SHALL lose nothing and SHALL NOT block the others.
REQ-023 rsp_ready high outside RESP SHALL be ignored.
REQ-024 Operands of non-granted requesters SHALL NOT affect any output.

Reset
REQ-025 While rst is high, the block SHALL hold state IDLE, round-robin pointer 0 (requester 0 highest priority), req_ready 0, rsp_valid 0, rsp_sum 0, rsp_carry 0 and rsp_id 0.
REQ-026 Reset asserted during CALC or RESP SHALL discard the in-flight transaction; no response SHALL appear after release.
REQ-027 The first grant SHALL be possible in the first cycle after rst deasserts.

Configuration
REQ-028 Macro SHARED_ADDER_SAT_EN selects saturating arithmetic:
  - Defined: on carry-out, rsp_sum SHALL be all-ones and rsp_carry SHALL still be 1.
  - Undefined: rsp_sum SHALL wrap per REQ-018.

Structure
REQ-029 Package shared_adder_pkg SHALL hold the FSM state enum (IDLE/CALC/RESP) and the default NUM_REQ and WIDTH constants.
REQ-030 The adder SHALL be a separate combinational sub-module, add_core: inputs a and b, outputs sum and carry, with saturation inside it under SHARED_ADDER_SAT_EN.
REQ-031 The arbiter and FSM SHALL live in shared_adder_arb.

Verification
REQ-032 Single add: requester 0 with a=10, b=15 -> req_ready=0001 at N; rsp_sum=25, carry=0, id=0 at N+2.
REQ-033 Overflow: requester 2 with a=200, b=100 -> sum=44, carry=1 when SAT_EN is undefined; sum=255, carry=1 when SAT_EN is defined.
REQ-034 Fairness: all four requesters valid continuously, rsp_ready tied 1 -> grant order 0,1,2,3,0, one grant every 3 cycles.
REQ-035 Backpressure: rsp_ready held 0 for 5 cycles in RESP -> outputs stable, req_ready all-zero, then return to IDLE on the edge where rsp_ready=1.
REQ-036 Reset mid-operation: rst pulsed in CALC -> rsp_valid stays 0, pointer back to 0, next grant goes to the lowest valid index.
REQ-037 Idle/withdraw: requester 1 drops req_valid before its grant -> no grant to 1, no spurious rsp_valid.
